// File: rtl/otp_pkg.sv
// Shared types and constants for the OTP issuer and verifier.
package otp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        ARMED = 2'd2
    } otp_state_e;

    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam int unsigned OTP_DIGITS   = 8;
    localparam int unsigned IDX_W        = 3;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

    // Fold each hex nibble into 0-9 so the code can be typed on a keypad.
    function automatic logic [31:0] to_decimal(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < OTP_DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd10) r[4*i +: 4] = v[4*i +: 4] - 4'd10;
        end
        return r;
    endfunction

    // Digit idx of the code, counting from the most significant nibble.
    function automatic logic [3:0] nibble(input logic [31:0] v, input logic [IDX_W-1:0] idx);
        logic [4:0] sh;
        sh = {3'(OTP_DIGITS - 1) - idx, 2'b00};
        return 4'(v >> sh);
    endfunction

endpackage

// File: rtl/otp_lfsr.sv
// Free-running 32-bit Galois LFSR; a nonzero seed keeps it off the all-zero state.
module otp_lfsr
    import otp_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] lfsr
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/otp_issuer.sv
// Generates a one-time code, streams it MSB-nibble first, then arms it for the verifier.
// Build option OTP_DECIMAL_EN restricts captured digits to 0-9.
module otp_issuer
    import otp_pkg::*;
#(
    parameter int unsigned OTP_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter logic [31:0] SEED        = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_access,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [3:0]       tx_digit,
    output logic             tx_last,
    input  logic             consume,
    output logic [OTP_W-1:0] otp_value,
    output logic             otp_valid,
    output logic             expired,
    output logic             busy
);

    localparam int unsigned     TMR_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OTP_DIGITS - 1);

    logic [31:0] lfsr;
    logic [31:0] lfsr_cap;

    otp_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .lfsr  (lfsr)
    );

`ifdef OTP_DECIMAL_EN
    assign lfsr_cap = to_decimal(lfsr);
`else
    assign lfsr_cap = lfsr;
`endif

    otp_state_e       state_q, state_d;
    logic [31:0]      otp_q, otp_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             tx_valid_q, tx_valid_d;
    logic [3:0]       tx_digit_q, tx_digit_d;
    logic             tx_last_q, tx_last_d;
    logic [OTP_W-1:0] otp_value_q, otp_value_d;
    logic             otp_valid_q, otp_valid_d;
    logic             expired_q, expired_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        otp_d     = otp_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        expired_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_access) begin
                    otp_d   = lfsr_cap;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_valid_q && tx_ready) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = ARMED;
                        timer_d = TMR_LOAD;
                    end
                end
            end
            ARMED: begin
                // consume takes priority over a same-cycle timeout
                if (consume) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    state_d   = IDLE;
                    expired_d = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are precomputed from next state so they leave the flops aligned with it.
        tx_valid_d  = (state_d == SEND);
        tx_digit_d  = tx_valid_d ? nibble(otp_d, idx_d) : 4'h0;
        tx_last_d   = tx_valid_d && (idx_d == LAST_IDX);
        otp_valid_d = (state_d == ARMED);
        otp_value_d = otp_valid_d ? OTP_W'(otp_d) : '0;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            otp_q       <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            tx_valid_q  <= 1'b0;
            tx_digit_q  <= 4'h0;
            tx_last_q   <= 1'b0;
            otp_value_q <= '0;
            otp_valid_q <= 1'b0;
            expired_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            otp_q       <= otp_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            tx_valid_q  <= tx_valid_d;
            tx_digit_q  <= tx_digit_d;
            tx_last_q   <= tx_last_d;
            otp_value_q <= otp_value_d;
            otp_valid_q <= otp_valid_d;
            expired_q   <= expired_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_digit  = tx_digit_q;
    assign tx_last   = tx_last_q;
    assign otp_value = otp_value_q;
    assign otp_valid = otp_valid_q;
    assign expired   = expired_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_otp_issuer.sv
// Self-checking bench for otp_issuer against a cycle-count based LFSR/code model.
module tb_otp_issuer;

    localparam int unsigned TMO    = 16;
    localparam logic [31:0] SEED_A = 32'h0000_0001;
    localparam logic [31:0] SEED_B = 32'hFA3C_0B19;
`ifdef OTP_DECIMAL_EN
    localparam logic [31:0] EXP_B  = 32'h5032_0119;
`else
    localparam logic [31:0] EXP_B  = 32'hFA3C_0B19;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_access, tx_ready, consume;
    logic        tx_valid, tx_last, otp_valid, expired, busy;
    logic [3:0]  tx_digit;
    logic [31:0] otp_value;

    logic        req_b, tx_ready_b, consume_b;
    logic        tx_valid_b, tx_last_b, otp_valid_b, expired_b, busy_b;
    logic [3:0]  tx_digit_b;
    logic [31:0] otp_value_b;

    int n_tests = 0;
    int n_fail  = 0;
    int ecnt    = 0;
    int b_exp_cnt = 0;

    always #5 clk = ~clk;

    otp_issuer #(.OTP_W(32), .TIMEOUT_CYC(TMO), .SEED(SEED_A)) dut (
        .clk(clk), .rst_n(rst_n), .req_access(req_access),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_digit(tx_digit), .tx_last(tx_last),
        .consume(consume), .otp_value(otp_value), .otp_valid(otp_valid),
        .expired(expired), .busy(busy)
    );

    otp_issuer #(.OTP_W(32), .TIMEOUT_CYC(TMO), .SEED(SEED_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_access(req_b),
        .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_digit(tx_digit_b), .tx_last(tx_last_b),
        .consume(consume_b), .otp_value(otp_value_b), .otp_valid(otp_valid_b),
        .expired(expired_b), .busy(busy_b)
    );

    // Edges since reset release: the LFSR seen before edge k is SEED advanced k times.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    always @(posedge clk) begin
        if (rst_n && expired_b) b_exp_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_adv(input logic [31:0] seed, input int n);
        logic [31:0] x;
        x = seed;
        for (int i = 0; i < n; i++) x = (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
        return x;
    endfunction

    function automatic logic [31:0] model_code(input logic [31:0] raw);
`ifdef OTP_DECIMAL_EN
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 8; i++) begin
            int d;
            d = int'((raw >> (4 * i)) & 32'hF);
            if (d >= 10) d = d - 10;
            r = r | (32'(d) << (4 * i));
        end
        return r;
`else
        return raw;
`endif
    endfunction

    function automatic logic [3:0] digit_of(input logic [31:0] v, input int i);
        return 4'(v >> (28 - 4 * i));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stream one code out of dut, optionally with a 1,0,0,1 then random ready pattern.
    task automatic deliver(input logic [31:0] exp, input bit bp, input string tag);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < 8 && cyc < 100) begin
            if (!bp)         tx_ready = 1'b1;
            else if (cyc < 4) tx_ready = (cyc == 0 || cyc == 3);
            else             tx_ready = 1'($urandom_range(0, 1));
            if (!tx_valid) begin
                check_eq({tag, "_tx_valid"}, {31'b0, tx_valid}, 32'd1);
                break;
            end
            check_eq({tag, "_digit"}, {28'b0, tx_digit}, {28'b0, digit_of(exp, got)});
            check_eq({tag, "_last"}, {31'b0, tx_last}, {31'b0, (got == 7)});
            if (tx_ready) got++;
            step();
            cyc++;
        end
        tx_ready = 1'b0;
        check_eq({tag, "_handshakes"}, 32'(got), 32'd8);
        check_eq({tag, "_armed_valid"}, {31'b0, otp_valid}, 32'd1);
        check_eq({tag, "_armed_value"}, otp_value, exp);
        check_eq({tag, "_tx_idle"}, {31'b0, tx_valid}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp1;
        logic [31:0] exp2;
        int n;
        int k;

        rst_n = 1'b0;
        req_access = 1'b0; tx_ready = 1'b0; consume = 1'b0;
        req_b = 1'b0; tx_ready_b = 1'b0; consume_b = 1'b0;
        #3;
        check_eq("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check_eq("rst_tx_digit", {28'b0, tx_digit}, 32'd0);
        check_eq("rst_tx_last", {31'b0, tx_last}, 32'd0);
        check_eq("rst_otp_value", otp_value, 32'd0);
        check_eq("rst_otp_valid", {31'b0, otp_valid}, 32'd0);
        check_eq("rst_expired", {31'b0, expired}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);

        // Basic delivery; dut_b demonstrates the digit folding of the seed value.
        @(negedge clk);
        rst_n = 1'b1;
        req_access = 1'b1; req_b = 1'b1;
        tx_ready = 1'b1; tx_ready_b = 1'b1;
        step();
        req_access = 1'b0; req_b = 1'b0;
        check_eq("basic_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_eq("basic_digit", {28'b0, tx_digit}, {28'b0, digit_of(model_code(SEED_A), i)});
            check_eq("basic_last", {31'b0, tx_last}, {31'b0, (i == 7)});
            check_eq("b_digit", {28'b0, tx_digit_b}, {28'b0, digit_of(EXP_B, i)});
            check_eq("b_last", {31'b0, tx_last_b}, {31'b0, (i == 7)});
            step();
        end
        tx_ready = 1'b0; tx_ready_b = 1'b0;
        check_eq("basic_otp_valid", {31'b0, otp_valid}, 32'd1);
        check_eq("basic_otp_value", otp_value, 32'h0000_0001);
        check_eq("b_otp_value", otp_value_b, EXP_B);

        // Expiry with no consume.
        n = 0;
        while (otp_valid && n < 100) begin
            check_eq("exp_early_pulse", {31'b0, expired}, 32'd0);
            n++;
            step();
        end
        check_eq("exp_valid_cycles", 32'(n), 32'(TMO));
        check_eq("exp_pulse", {31'b0, expired}, 32'd1);
        check_eq("exp_busy", {31'b0, busy}, 32'd0);
        check_eq("exp_value_zero", otp_value, 32'd0);
        step();
        check_eq("exp_pulse_width", {31'b0, expired}, 32'd0);

        // Consume in the very cycle the timer reaches zero.
        req_access = 1'b1;
        step();
        req_access = 1'b0;
        exp1 = model_code(lfsr_adv(SEED_A, ecnt - 1));
        deliver(exp1, 1'b1, "last_cyc");
        repeat (TMO - 1) step();
        check_eq("last_cyc_still_valid", {31'b0, otp_valid}, 32'd1);
        consume = 1'b1;
        step();
        consume = 1'b0;
        check_eq("last_cyc_valid_drop", {31'b0, otp_valid}, 32'd0);
        check_eq("last_cyc_no_expire", {31'b0, expired}, 32'd0);
        check_eq("last_cyc_busy", {31'b0, busy}, 32'd0);
        step();
        check_eq("last_cyc_no_expire2", {31'b0, expired}, 32'd0);
        check_eq("b_one_expiry", 32'(b_exp_cnt), 32'd1);
        check_eq("b_idle", {31'b0, busy_b}, 32'd0);

        // req_access held high throughout: only IDLE edges capture.
        req_access = 1'b1;
        step();
        exp1 = model_code(lfsr_adv(SEED_A, ecnt - 1));
        for (int r = 0; r < 3; r++) begin
            deliver(exp1, 1'b1, "held_req");
            k = $urandom_range(0, TMO - 2);
            repeat (k) begin
                step();
                check_eq("held_value_stable", otp_value, exp1);
            end
            consume = 1'b1;
            step();
            consume = 1'b0;
            check_eq("held_consumed_idle", {31'b0, busy}, 32'd0);
            check_eq("held_no_expire", {31'b0, expired}, 32'd0);
            step();
            exp2 = model_code(lfsr_adv(SEED_A, ecnt - 1));
            check_eq("held_recapture", {31'b0, busy}, 32'd1);
            exp1 = exp2;
        end
        req_access = 1'b0;
        deliver(exp1, 1'b0, "held_final");
        consume = 1'b1;
        step();
        consume = 1'b0;

        // Reset in the middle of delivery.
        req_access = 1'b1;
        step();
        req_access = 1'b0;
        tx_ready = 1'b1;
        step();
        step();
        tx_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check_eq("mid_rst_tx_digit", {28'b0, tx_digit}, 32'd0);
        check_eq("mid_rst_tx_last", {31'b0, tx_last}, 32'd0);
        check_eq("mid_rst_busy", {31'b0, busy}, 32'd0);
        check_eq("mid_rst_otp_valid", {31'b0, otp_valid}, 32'd0);
        check_eq("mid_rst_otp_value", otp_value, 32'd0);
        check_eq("mid_rst_expired", {31'b0, expired}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_access = 1'b1;
        step();
        req_access = 1'b0;
        deliver(model_code(SEED_A), 1'b1, "post_rst_seed");
        consume = 1'b1;
        step();
        consume = 1'b0;
        check_eq("post_rst_idle", {31'b0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
